// File: rtl/alu_p0_issue_queue_pkg.sv
// Shared types for the ALU pipe 0 issue queue: scheduled instruction and queue entry.
package alu_p0_issue_queue_pkg;

   localparam int unsigned PHYS_TAG_W = 7;

   typedef struct packed {
      logic [31:0]           pc;
      logic [PHYS_TAG_W-1:0] rs1;
      logic [PHYS_TAG_W-1:0] rs2;
      logic [PHYS_TAG_W-1:0] rd;
      logic [31:0]           raw;
   } instruction_scheduled_t;

   typedef struct packed {
      logic                   valid;
      logic                   rs1_rdy;
      logic                   rs2_rdy;
      instruction_scheduled_t instr;
   } iq_entry_t;

   // Physical tag 0 is the hard-wired zero register and never waits on a writeback.
   function automatic logic tag_is_zero(input logic [PHYS_TAG_W-1:0] tag);
      return tag == '0;
   endfunction

endpackage

// File: rtl/alu_p0_issue_queue_select.sv
// Lowest-index-first picker over the issue queue request vector (index 0 is oldest).
module alu_iq_select #(
   parameter int unsigned DEPTH = 8
) (
   input  logic [DEPTH-1:0]         req,
   output logic [DEPTH-1:0]         grant,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     found
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            idx      = i[IDX_W-1:0];
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_p0_issue_queue.sv
// Collapsing issue queue for ALU pipe 0 with tag wakeup and oldest-ready select.
// Define ALU_IQ_WAKEUP_BYPASS_EN to let same-cycle writeback tags count as ready in select.
module alu_p0_issue_queue
   import alu_p0_issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned NUM_WB = 2,
   parameter int unsigned TAG_W  = PHYS_TAG_W
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             enq_valid,
   output logic                             enq_ready,
   input  instruction_scheduled_t           enq_instr,
   input  logic                             enq_rs1_rdy,
   input  logic                             enq_rs2_rdy,
   input  logic [NUM_WB-1:0]                wb_valid,
   input  logic [NUM_WB-1:0][TAG_W-1:0]     wb_tag,
   output logic                             issue_valid,
   output instruction_scheduled_t           issue_instr,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   iq_entry_t [DEPTH-1:0] entries_q, entries_d, woken;
   logic [DEPTH-1:0]      hit1, hit2, req, grant;
   logic [IDX_W-1:0]      issue_idx;
   logic                  found, issue_fire, enq_fire;
   logic                  new_hit1, new_hit2;
   logic [CNT_W-1:0]      count_q, count_d, tail;
   iq_entry_t             new_entry;

   // Writeback tag compare for every resident entry and for the incoming op.
   always_comb begin
      hit1     = '0;
      hit2     = '0;
      new_hit1 = 1'b0;
      new_hit2 = 1'b0;
      for (int w = 0; w < int'(NUM_WB); w++) begin
         new_hit1 |= wb_valid[w] & (wb_tag[w] == enq_instr.rs1);
         new_hit2 |= wb_valid[w] & (wb_tag[w] == enq_instr.rs2);
         for (int i = 0; i < int'(DEPTH); i++) begin
            hit1[i] |= wb_valid[w] & (wb_tag[w] == entries_q[i].instr.rs1);
            hit2[i] |= wb_valid[w] & (wb_tag[w] == entries_q[i].instr.rs2);
         end
      end
   end

   always_comb begin
      req = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
         req[i] = entries_q[i].valid & (entries_q[i].rs1_rdy | hit1[i])
                                     & (entries_q[i].rs2_rdy | hit2[i]);
`else
         req[i] = entries_q[i].valid & entries_q[i].rs1_rdy & entries_q[i].rs2_rdy;
`endif
      end
   end

   alu_iq_select #(
      .DEPTH (DEPTH)
   ) u_select (
      .req   (req),
      .grant (grant),
      .idx   (issue_idx),
      .found (found)
   );

   assign issue_fire  = found & ~flush;
   assign issue_valid = issue_fire;
   assign enq_ready   = (count_q != CNT_W'(DEPTH));
   assign enq_fire    = enq_valid & enq_ready & ~flush;
   assign count       = count_q;
   // The issued op leaves this edge, so the new op lands one slot lower.
   assign tail        = count_q - CNT_W'(issue_fire);

   always_comb begin
      issue_instr = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (grant[i] && issue_fire) issue_instr = entries_q[i].instr;
      end
   end

   always_comb begin
      new_entry         = '0;
      new_entry.valid   = 1'b1;
      new_entry.instr   = enq_instr;
      new_entry.rs1_rdy = enq_rs1_rdy | tag_is_zero(enq_instr.rs1) | new_hit1;
      new_entry.rs2_rdy = enq_rs2_rdy | tag_is_zero(enq_instr.rs2) | new_hit2;
   end

   // Wakeup, collapse above the issued slot, then append at the compacted tail.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         woken[i]         = entries_q[i];
         woken[i].rs1_rdy = entries_q[i].rs1_rdy | hit1[i];
         woken[i].rs2_rdy = entries_q[i].rs2_rdy | hit2[i];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         entries_d[i] = woken[i];
         if (issue_fire && i >= int'(issue_idx)) begin
            if (i < int'(DEPTH) - 1) entries_d[i] = woken[(i + 1) % int'(DEPTH)];
            else                     entries_d[i] = '0;
         end
         if (enq_fire && i == int'(tail)) entries_d[i] = new_entry;
      end
      if (flush) entries_d = '0;
   end

   always_comb begin
      if (flush) count_d = '0;
      else       count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entries_q <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         count_q   <= count_d;
      end
   end

endmodule
